ysyx_22040759_gpr: RTL and testbench

- RV64 integer general-purpose register file: 32 x 64-bit registers, x0 hardwired to zero.
- Two combinational read ports and one synchronous write port.
- Instantiated in the decode stage: read addresses come from instruction rs1/rs2, the write port is driven by the writeback bus.
- Full register array exported for difftest comparison.

---
 rtl/ysyx_22040759_gpr.sv | 58 +++++
 tb/tb_ysyx_22040759_gpr.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040759_gpr.sv
// RV64 integer register file: 32 x 64-bit, x0 hardwired to zero, 2 comb read / 1 sync write.
// Define GPR_WRITE_BYPASS_EN to forward same-cycle writeback data onto the read ports.
module ysyx_22040759_gpr #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned NREG = 32,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   waddr,
  input  logic            wen,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  output logic [XLEN-1:0] regs_o [NREG]
);

  // x0 has no storage; only x1..x(NREG-1) are flops.
  logic [XLEN-1:0] regs_q [NREG-1:1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wen) begin
      for (int i = 1; i < NREG; i++) begin
        if (int'(waddr) == i) begin
          regs_q[i] <= wdata;
        end
      end
    end
  end

  always_comb begin
    regs_o[0] = '0;
    for (int i = 1; i < NREG; i++) begin
      regs_o[i] = regs_q[i];
    end
  end

  always_comb begin
    rdata1 = regs_o[raddr1];
    rdata2 = regs_o[raddr2];
`ifdef GPR_WRITE_BYPASS_EN
    // Write-before-read: decode sees writeback data in the same cycle.
    if (wen && !rst && (waddr != '0) && (waddr == raddr1)) begin
      rdata1 = wdata;
    end
    if (wen && !rst && (waddr != '0) && (waddr == raddr2)) begin
      rdata2 = wdata;
    end
`endif
  end

endmodule

// File: tb/tb_ysyx_22040759_gpr.sv
// Directed self-checking bench for ysyx_22040759_gpr using an expected-value scoreboard
// and a reference register model.
module tb_ysyx_22040759_gpr;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] wdata;
  logic [4:0]  waddr;
  logic        wen;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [63:0] rdata1;
  logic [63:0] rdata2;
  logic [63:0] regs_o [32];

  ysyx_22040759_gpr dut (
    .clk    (clk),
    .rst    (rst),
    .wdata  (wdata),
    .waddr  (waddr),
    .wen    (wen),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .regs_o (regs_o)
  );

  always #5 clk = ~clk;

  logic [63:0] model [32];
  logic [63:0] sb [$];
  int          tests = 0;
  int          fails = 0;

  task automatic push_exp(input logic [63:0] e);
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL %s: got %h, no expected value queued", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s: got %h expected %h", tag, obs, e);
      end
    end
  endtask

  // Drive one clock edge with current inputs, then update the reference model.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 64'h0;
    end else if (wen && waddr != 5'd0) begin
      model[waddr] = wdata;
    end
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [63:0] d);
    wen = 1'b1; waddr = a; wdata = d;
    tick();
    wen = 1'b0;
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 32; i++) begin
      push_exp(model[i]);
      chk($sformatf("%s_regs_o[%0d]", tag, i), regs_o[i]);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 64'h0;
    rst = 1'b1; wen = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
    tick();
    rst = 1'b0;
    #1;
    check_all_regs("init_reset");

    // Reset clears a written register; reset beats a simultaneous write.
    wr(5'd5, 64'hDEAD_BEEF);
    raddr1 = 5'd5; #1;
    push_exp(64'hDEAD_BEEF); chk("pre_reset_x5", rdata1);
    rst = 1'b1; wen = 1'b1; waddr = 5'd3; wdata = 64'h5555;
    tick();
    rst = 1'b0; wen = 1'b0;
    raddr1 = 5'd5; raddr2 = 5'd3; #1;
    push_exp(64'h0); chk("reset_x5", rdata1);
    push_exp(64'h0); chk("reset_wr_dropped_x3", rdata2);
    check_all_regs("after_reset");

    // Basic write/read.
    wr(5'd1, 64'h0123_4567_89AB_CDEF);
    wr(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    raddr1 = 5'd1; raddr2 = 5'd31; #1;
    push_exp(64'h0123_4567_89AB_CDEF); chk("basic_rdata1", rdata1);
    push_exp(64'hFFFF_FFFF_FFFF_FFFF); chk("basic_rdata2", rdata2);
    push_exp(64'h0123_4567_89AB_CDEF); chk("basic_regs_o1", regs_o[1]);
    push_exp(64'hFFFF_FFFF_FFFF_FFFF); chk("basic_regs_o31", regs_o[31]);

    // Writes to x0 are ignored.
    wr(5'd0, 64'h1234);
    raddr1 = 5'd0; #1;
    push_exp(64'h0); chk("x0_rdata1", rdata1);
    check_all_regs("x0_write");

    // wen gating and dual-port same address.
    wen = 1'b0; waddr = 5'd7; wdata = 64'hAAAA;
    tick();
    raddr1 = 5'd7; raddr2 = 5'd7; #1;
    push_exp(64'h0); chk("wen0_x7_p1", rdata1);
    push_exp(64'h0); chk("wen0_x7_p2", rdata2);

    // Same-cycle read/write hazard.
    wr(5'd10, 64'h11);
    wen = 1'b1; waddr = 5'd10; wdata = 64'h22; raddr1 = 5'd10; #1;
`ifdef GPR_WRITE_BYPASS_EN
    push_exp(64'h22); chk("hazard_same_cycle", rdata1);
`else
    push_exp(64'h11); chk("hazard_same_cycle", rdata1);
`endif
    push_exp(64'h11); chk("hazard_regs_o_before", regs_o[10]);
    tick();
    wen = 1'b0; #1;
    push_exp(64'h22); chk("hazard_next_cycle", rdata1);
    push_exp(64'h22); chk("hazard_regs_o_after", regs_o[10]);

    // Sweep every register through both ports and regs_o.
    for (int i = 1; i < 32; i++) begin
      wr(i[4:0], 64'(i) * 64'h0101_0101_0101_0101);
    end
    for (int i = 0; i < 32; i++) begin
      raddr1 = i[4:0];
      raddr2 = 5'(31 - i);
      #1;
      push_exp(64'(i) * 64'h0101_0101_0101_0101);
      chk($sformatf("sweep_p1_x%0d", i), rdata1);
      push_exp(64'(31 - i) * 64'h0101_0101_0101_0101);
      chk($sformatf("sweep_p2_x%0d", 31 - i), rdata2);
    end
    check_all_regs("sweep");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
